// File: rtl/rob_recover_if.sv
// Bus bundle for the reorder buffer: dispatch, writeback, retire and flush.
// master = the core side (rename/execute), slave = the ROB itself.
interface rob_recover_if #(
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned COMMIT_WIDTH   = 2,
    parameter int unsigned WB_WIDTH       = 4,
    parameter int unsigned ARCH_REGS      = 32,
    parameter int unsigned PHYS_REGS      = 64
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned AR_W  = $clog2(ARCH_REGS);
    localparam int unsigned PR_W  = $clog2(PHYS_REGS);

    logic [DISPATCH_WIDTH-1:0]             disp_valid_i;
    logic [DISPATCH_WIDTH-1:0]             disp_rd_wen_i;
    logic [DISPATCH_WIDTH-1:0][AR_W-1:0]   disp_rd_arch_i;
    logic [DISPATCH_WIDTH-1:0][PR_W-1:0]   disp_new_prf_i;
    logic [DISPATCH_WIDTH-1:0][PR_W-1:0]   disp_old_prf_i;
    logic [DISPATCH_WIDTH-1:0]             disp_ready_o;
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]  disp_rob_idx_o;

    logic [WB_WIDTH-1:0]                   wb_valid_i;
    logic [WB_WIDTH-1:0][IDX_W-1:0]        wb_rob_idx_i;
    logic [WB_WIDTH-1:0]                   wb_exception_i;
    logic [WB_WIDTH-1:0]                   wb_mispred_i;

    logic [COMMIT_WIDTH-1:0]               commit_valid_o;
    logic [COMMIT_WIDTH-1:0]               commit_rd_wen_o;
    logic [COMMIT_WIDTH-1:0][AR_W-1:0]     commit_rd_arch_o;
    logic [COMMIT_WIDTH-1:0][PR_W-1:0]     commit_new_prf_o;
    logic [COMMIT_WIDTH-1:0][PR_W-1:0]     commit_old_prf_o;

    logic                                  flush_o;
    logic                                  flush_exc_o;
    logic [IDX_W-1:0]                      flush_rob_idx_o;
    logic [CNT_W-1:0]                      count_o;

    modport master (
        output disp_valid_i, disp_rd_wen_i, disp_rd_arch_i, disp_new_prf_i, disp_old_prf_i,
        input  disp_ready_o, disp_rob_idx_o,
        output wb_valid_i, wb_rob_idx_i, wb_exception_i, wb_mispred_i,
        input  commit_valid_o, commit_rd_wen_o, commit_rd_arch_o, commit_new_prf_o, commit_old_prf_o,
        input  flush_o, flush_exc_o, flush_rob_idx_o, count_o
    );

    modport slave (
        input  disp_valid_i, disp_rd_wen_i, disp_rd_arch_i, disp_new_prf_i, disp_old_prf_i,
        output disp_ready_o, disp_rob_idx_o,
        input  wb_valid_i, wb_rob_idx_i, wb_exception_i, wb_mispred_i,
        output commit_valid_o, commit_rd_wen_o, commit_rd_arch_o, commit_new_prf_o, commit_old_prf_o,
        output flush_o, flush_exc_o, flush_rob_idx_o, count_o
    );
endinterface

// File: rtl/rob_recover.sv
// In-order-retire reorder buffer with precise recovery.
// Retires up to COMMIT_WIDTH ready entries per cycle; a mispredicted branch
// commits and then squashes younger work, a faulting entry squashes without
// committing. Optional perf counters are enabled by defining ROB_PERF_CNT_EN.
module rob_recover #(
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned COMMIT_WIDTH   = 2,
    parameter int unsigned WB_WIDTH       = 4,
    parameter int unsigned ARCH_REGS      = 32,
    parameter int unsigned PHYS_REGS      = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    rob_recover_if.slave  bus
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_commit_o,
    output logic [31:0]   perf_flush_o
`endif
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned AR_W  = $clog2(ARCH_REGS);
    localparam int unsigned PR_W  = $clog2(PHYS_REGS);
    localparam int unsigned DW_W  = $clog2(DISPATCH_WIDTH + 1);
    localparam int unsigned CW_W  = $clog2(COMMIT_WIDTH + 1);

    // Circular increment; inc never exceeds DEPTH so one subtraction is enough.
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned       inc);
        int unsigned s;
        s = 32'(base) + inc;
        if (s >= DEPTH) s = s - DEPTH;
        return IDX_W'(s);
    endfunction

    logic [DEPTH-1:0] valid_q, ready_q, exc_q, mispred_q, rd_wen_q;
    logic [AR_W-1:0]  rd_arch_q [DEPTH];
    logic [PR_W-1:0]  new_prf_q [DEPTH];
    logic [PR_W-1:0]  old_prf_q [DEPTH];
    logic [IDX_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic [COMMIT_WIDTH-1:0]              commit_c;
    logic [COMMIT_WIDTH-1:0][IDX_W-1:0]   ridx_c;
    logic [CW_W-1:0]                      n_ret_c;
    logic                                 flush_c, flush_exc_c;
    logic [IDX_W-1:0]                     flush_idx_c;
    logic                                 alive_c;

    logic [CNT_W-1:0]                     free_c;
    logic [DISPATCH_WIDTH-1:0]            ready_c, acc_c;
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] aidx_c;
    logic [DW_W-1:0]                      n_acc_c;
    int unsigned                          nbelow_c;

    // Retire scan from head: stop at the first not-ready entry, a fault or a mispredict.
    always_comb begin
        commit_c    = '0;
        ridx_c      = '0;
        n_ret_c     = '0;
        flush_c     = 1'b0;
        flush_exc_c = 1'b0;
        flush_idx_c = '0;
        alive_c     = 1'b1;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            ridx_c[k] = idx_add(head_q, k);
            if (alive_c && valid_q[ridx_c[k]] && ready_q[ridx_c[k]]) begin
                if (exc_q[ridx_c[k]]) begin
                    flush_c     = 1'b1;
                    flush_exc_c = 1'b1;
                    flush_idx_c = ridx_c[k];
                    alive_c     = 1'b0;
                end else begin
                    commit_c[k] = 1'b1;
                    n_ret_c     = n_ret_c + CW_W'(1);
                    if (mispred_q[ridx_c[k]]) begin
                        flush_c     = 1'b1;
                        flush_idx_c = ridx_c[k];
                        alive_c     = 1'b0;
                    end
                end
            end else begin
                alive_c = 1'b0;
            end
        end
    end

    // Retire payload, zeroed on idle lanes.
    always_comb begin
        bus.commit_valid_o   = commit_c;
        bus.commit_rd_wen_o  = '0;
        bus.commit_rd_arch_o = '0;
        bus.commit_new_prf_o = '0;
        bus.commit_old_prf_o = '0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_c[k]) begin
                bus.commit_rd_wen_o[k]  = rd_wen_q[ridx_c[k]];
                bus.commit_rd_arch_o[k] = rd_arch_q[ridx_c[k]];
                bus.commit_new_prf_o[k] = new_prf_q[ridx_c[k]];
                bus.commit_old_prf_o[k] = old_prf_q[ridx_c[k]];
            end
        end
    end

    // Dispatch: lane readiness from registered occupancy, indices packed over valid lanes.
    always_comb begin
        free_c   = CNT_W'(DEPTH) - count_q;
        ready_c  = '0;
        acc_c    = '0;
        aidx_c   = '0;
        n_acc_c  = '0;
        nbelow_c = 0;
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            ready_c[i] = !flush_c && (32'(free_c) > i);
            aidx_c[i]  = idx_add(tail_q, nbelow_c);
            acc_c[i]   = bus.disp_valid_i[i] && ready_c[i];
            if (bus.disp_valid_i[i]) nbelow_c = nbelow_c + 1;
            if (acc_c[i]) n_acc_c = n_acc_c + DW_W'(1);
        end
    end

    assign bus.disp_ready_o    = ready_c;
    assign bus.disp_rob_idx_o  = aidx_c;
    assign bus.flush_o         = flush_c;
    assign bus.flush_exc_o     = flush_exc_c;
    assign bus.flush_rob_idx_o = flush_idx_c;
    assign bus.count_o         = count_q;

    // Entry status bits and pointers; a flush empties the whole buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= '0;
            ready_q   <= '0;
            exc_q     <= '0;
            mispred_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else if (flush_c) begin
            valid_q   <= '0;
            ready_q   <= '0;
            exc_q     <= '0;
            mispred_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
                if (commit_c[k]) valid_q[ridx_c[k]] <= 1'b0;
            end
            for (int unsigned w = 0; w < WB_WIDTH; w++) begin
                if (bus.wb_valid_i[w] && (32'(bus.wb_rob_idx_i[w]) < DEPTH) &&
                    valid_q[bus.wb_rob_idx_i[w]]) begin
                    ready_q[bus.wb_rob_idx_i[w]]   <= 1'b1;
                    exc_q[bus.wb_rob_idx_i[w]]     <= bus.wb_exception_i[w];
                    mispred_q[bus.wb_rob_idx_i[w]] <= bus.wb_mispred_i[w];
                end
            end
            for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
                if (acc_c[i]) begin
                    valid_q[aidx_c[i]]   <= 1'b1;
                    ready_q[aidx_c[i]]   <= 1'b0;
                    exc_q[aidx_c[i]]     <= 1'b0;
                    mispred_q[aidx_c[i]] <= 1'b0;
                end
            end
            head_q  <= idx_add(head_q, 32'(n_ret_c));
            tail_q  <= idx_add(tail_q, 32'(n_acc_c));
            count_q <= count_q + CNT_W'(n_acc_c) - CNT_W'(n_ret_c);
        end
    end

    // Payload storage; only read behind a valid bit, so no reset needed.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            if (acc_c[i]) begin
                rd_wen_q[aidx_c[i]]  <= bus.disp_rd_wen_i[i];
                rd_arch_q[aidx_c[i]] <= bus.disp_rd_arch_i[i];
                new_prf_q[aidx_c[i]] <= bus.disp_new_prf_i[i];
                old_prf_q[aidx_c[i]] <= bus.disp_old_prf_i[i];
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [32:0] commit_sum_c, flush_sum_c;
    assign commit_sum_c = {1'b0, perf_commit_o} + 33'(n_ret_c);
    assign flush_sum_c  = {1'b0, perf_flush_o} + 33'(flush_c);

    // Saturating totals of committed instructions and flushes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_commit_o <= '0;
            perf_flush_o  <= '0;
        end else begin
            perf_commit_o <= commit_sum_c[32] ? '1 : commit_sum_c[31:0];
            perf_flush_o  <= flush_sum_c[32]  ? '1 : flush_sum_c[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_rob_recover.sv
// Directed bench for rob_recover: fill, in-order retire, wrap, mispredict,
// exception and asynchronous reset scenarios with hand-computed expectations.
module tb_rob_recover;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned AR_W  = 5;
    localparam int unsigned PR_W  = 6;

    logic clk;
    logic reset_n;
    int   vec;
    int   err;

    rob_recover_if #(.DEPTH(DEPTH), .DISPATCH_WIDTH(2), .COMMIT_WIDTH(2), .WB_WIDTH(4),
                     .ARCH_REGS(32), .PHYS_REGS(64)) bus ();

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit;
    logic [31:0] perf_flush;
`endif

    rob_recover #(.DEPTH(DEPTH), .DISPATCH_WIDTH(2), .COMMIT_WIDTH(2), .WB_WIDTH(4),
                  .ARCH_REGS(32), .PHYS_REGS(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_commit_o (perf_commit),
        .perf_flush_o  (perf_flush)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        bus.disp_valid_i   = '0;
        bus.disp_rd_wen_i  = '0;
        bus.disp_rd_arch_i = '0;
        bus.disp_new_prf_i = '0;
        bus.disp_old_prf_i = '0;
        bus.wb_valid_i     = '0;
        bus.wb_rob_idx_i   = '0;
        bus.wb_exception_i = '0;
        bus.wb_mispred_i   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic disp2(input int a0, input int a1, input int n0, input int n1,
                         input int o0, input int o1);
        bus.disp_valid_i      = 2'b11;
        bus.disp_rd_wen_i     = 2'b11;
        bus.disp_rd_arch_i[0] = AR_W'(a0);
        bus.disp_rd_arch_i[1] = AR_W'(a1);
        bus.disp_new_prf_i[0] = PR_W'(n0);
        bus.disp_new_prf_i[1] = PR_W'(n1);
        bus.disp_old_prf_i[0] = PR_W'(o0);
        bus.disp_old_prf_i[1] = PR_W'(o1);
    endtask

    task automatic test_reset();
        #1;
        vec++;
        if (bus.count_o !== CNT_W'(0) || bus.commit_valid_o !== 2'b00 || bus.flush_o !== 1'b0 ||
            bus.disp_ready_o !== 2'b11 || bus.disp_rob_idx_o[0] !== IDX_W'(0)) begin
            err++;
            $display("FAIL reset: count=%0d commit=%b flush=%b ready=%b idx0=%0d, required 0 00 0 11 0",
                     bus.count_o, bus.commit_valid_o, bus.flush_o, bus.disp_ready_o, bus.disp_rob_idx_o[0]);
        end
    endtask

    task automatic test_fill();
        for (int c = 0; c < 16; c++) begin
            disp2(2*c, 2*c+1, 32+2*c, 33+2*c, 2*c, 2*c+1);
            if (c == 0) bus.disp_rd_wen_i = 2'b01;
            #1;
            vec++;
            if (bus.disp_ready_o !== 2'b11 || bus.disp_rob_idx_o[0] !== IDX_W'(2*c) ||
                bus.disp_rob_idx_o[1] !== IDX_W'(2*c+1)) begin
                err++;
                $display("FAIL fill c=%0d: ready=%b idx=%0d,%0d required 11 %0d,%0d", c,
                         bus.disp_ready_o, bus.disp_rob_idx_o[0], bus.disp_rob_idx_o[1], 2*c, 2*c+1);
            end
            tick();
        end
        disp2(0, 0, 0, 0, 0, 0);
        #1;
        vec++;
        if (bus.count_o !== CNT_W'(32) || bus.disp_ready_o !== 2'b00) begin
            err++;
            $display("FAIL full: count=%0d ready=%b required 32 00", bus.count_o, bus.disp_ready_o);
        end
        idle();
    endtask

    task automatic test_inorder();
        bus.wb_valid_i      = 4'b0001;
        bus.wb_rob_idx_i[0] = IDX_W'(1);
        #1;
        vec++;
        if (bus.commit_valid_o !== 2'b00) begin
            err++;
            $display("FAIL inorder_wb1: commit=%b required 00", bus.commit_valid_o);
        end
        tick();
        bus.wb_rob_idx_i[0] = IDX_W'(0);
        #1;
        vec++;
        if (bus.commit_valid_o !== 2'b00) begin
            err++;
            $display("FAIL inorder_idx1_only: commit=%b required 00", bus.commit_valid_o);
        end
        tick();
        idle();
        #1;
        vec++;
        if (bus.commit_valid_o !== 2'b11 || bus.commit_rd_wen_o !== 2'b01 ||
            bus.commit_rd_arch_o[0] !== AR_W'(0) || bus.commit_rd_arch_o[1] !== AR_W'(1) ||
            bus.commit_new_prf_o[0] !== PR_W'(32) || bus.commit_new_prf_o[1] !== PR_W'(33) ||
            bus.commit_old_prf_o[0] !== PR_W'(0) || bus.commit_old_prf_o[1] !== PR_W'(1)) begin
            err++;
            $display("FAIL inorder_commit: v=%b wen=%b arch=%0d,%0d new=%0d,%0d old=%0d,%0d required 11 01 0,1 32,33 0,1",
                     bus.commit_valid_o, bus.commit_rd_wen_o, bus.commit_rd_arch_o[0], bus.commit_rd_arch_o[1],
                     bus.commit_new_prf_o[0], bus.commit_new_prf_o[1], bus.commit_old_prf_o[0], bus.commit_old_prf_o[1]);
        end
        tick();
        #1;
        vec++;
        if (bus.count_o !== CNT_W'(30) || bus.commit_valid_o !== 2'b00) begin
            err++;
            $display("FAIL inorder_count: count=%0d commit=%b required 30 00", bus.count_o, bus.commit_valid_o);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        disp2(20, 21, 50, 51, 40, 41);
        #1;
        vec++;
        if (bus.disp_ready_o !== 2'b11 || bus.disp_rob_idx_o[0] !== IDX_W'(0) ||
            bus.disp_rob_idx_o[1] !== IDX_W'(1)) begin
            err++;
            $display("FAIL wrap_alloc: ready=%b idx=%0d,%0d required 11 0,1",
                     bus.disp_ready_o, bus.disp_rob_idx_o[0], bus.disp_rob_idx_o[1]);
        end
        tick();
        idle();
        for (int g = 0; g < 7; g++) begin
            bus.wb_valid_i = 4'b1111;
            for (int l = 0; l < 4; l++) bus.wb_rob_idx_i[l] = IDX_W'(2 + 4*g + l);
            tick();
        end
        idle();
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (bus.count_o == CNT_W'(4)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        vec++;
        if (!ok || bus.commit_valid_o !== 2'b00) begin
            err++;
            $display("FAIL wrap_drain: count=%0d commit=%b required 4 00", bus.count_o, bus.commit_valid_o);
        end
        bus.wb_valid_i      = 4'b1111;
        bus.wb_rob_idx_i[0] = IDX_W'(30);
        bus.wb_rob_idx_i[1] = IDX_W'(31);
        bus.wb_rob_idx_i[2] = IDX_W'(0);
        bus.wb_rob_idx_i[3] = IDX_W'(1);
        tick();
        idle();
        #1;
        vec++;
        if (bus.commit_valid_o !== 2'b11 || bus.commit_old_prf_o[0] !== PR_W'(30) ||
            bus.commit_old_prf_o[1] !== PR_W'(31) || bus.commit_rd_arch_o[0] !== AR_W'(30)) begin
            err++;
            $display("FAIL wrap_30_31: v=%b old=%0d,%0d arch0=%0d required 11 30,31 30",
                     bus.commit_valid_o, bus.commit_old_prf_o[0], bus.commit_old_prf_o[1], bus.commit_rd_arch_o[0]);
        end
        tick();
        #1;
        vec++;
        if (bus.commit_valid_o !== 2'b11 || bus.commit_old_prf_o[0] !== PR_W'(40) ||
            bus.commit_old_prf_o[1] !== PR_W'(41) || bus.commit_new_prf_o[0] !== PR_W'(50) ||
            bus.commit_new_prf_o[1] !== PR_W'(51)) begin
            err++;
            $display("FAIL wrap_0_1: v=%b old=%0d,%0d new=%0d,%0d required 11 40,41 50,51",
                     bus.commit_valid_o, bus.commit_old_prf_o[0], bus.commit_old_prf_o[1],
                     bus.commit_new_prf_o[0], bus.commit_new_prf_o[1]);
        end
        tick();
        #1;
        vec++;
        if (bus.count_o !== CNT_W'(0) || bus.commit_valid_o !== 2'b00 || bus.disp_rob_idx_o[0] !== IDX_W'(2)) begin
            err++;
            $display("FAIL wrap_empty: count=%0d commit=%b idx0=%0d required 0 00 2",
                     bus.count_o, bus.commit_valid_o, bus.disp_rob_idx_o[0]);
        end
    endtask

    task automatic test_mispredict();
        bit ok;
        disp2(2, 3, 2, 3, 2, 3);
        tick();
        idle();
        bus.disp_valid_i    = 2'b01;
        bus.wb_valid_i      = 4'b0011;
        bus.wb_rob_idx_i[0] = IDX_W'(2);
        bus.wb_rob_idx_i[1] = IDX_W'(3);
        #1;
        vec++;
        if (bus.disp_rob_idx_o[0] !== IDX_W'(4)) begin
            err++;
            $display("FAIL misp_alloc4: idx0=%0d required 4", bus.disp_rob_idx_o[0]);
        end
        tick();
        idle();
        bus.wb_valid_i      = 4'b0001;
        bus.wb_rob_idx_i[0] = IDX_W'(4);
        tick();
        idle();
        ok = 1'b0;
        for (int t = 0; t < 10; t++) begin
            #1;
            if (bus.count_o == CNT_W'(0)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        disp2(7, 8, 10, 11, 12, 13);
        #1;
        vec++;
        if (!ok || bus.disp_rob_idx_o[0] !== IDX_W'(5) || bus.disp_rob_idx_o[1] !== IDX_W'(6)) begin
            err++;
            $display("FAIL misp_alloc56: drained=%0d idx=%0d,%0d required 1 5,6",
                     ok, bus.disp_rob_idx_o[0], bus.disp_rob_idx_o[1]);
        end
        tick();
        idle();
        bus.wb_valid_i      = 4'b0011;
        bus.wb_rob_idx_i[0] = IDX_W'(5);
        bus.wb_rob_idx_i[1] = IDX_W'(6);
        bus.wb_mispred_i    = 4'b0001;
        tick();
        idle();
        #1;
        vec++;
        if (bus.commit_valid_o !== 2'b01 || bus.flush_o !== 1'b1 || bus.flush_exc_o !== 1'b0 ||
            bus.flush_rob_idx_o !== IDX_W'(5) || bus.disp_ready_o !== 2'b00 ||
            bus.commit_new_prf_o[0] !== PR_W'(10)) begin
            err++;
            $display("FAIL misp_flush: v=%b flush=%b exc=%b fidx=%0d ready=%b new0=%0d required 01 1 0 5 00 10",
                     bus.commit_valid_o, bus.flush_o, bus.flush_exc_o, bus.flush_rob_idx_o,
                     bus.disp_ready_o, bus.commit_new_prf_o[0]);
        end
        tick();
        #1;
        vec++;
        if (bus.count_o !== CNT_W'(0) || bus.flush_o !== 1'b0 || bus.disp_ready_o !== 2'b11 ||
            bus.disp_rob_idx_o[0] !== IDX_W'(0) || bus.commit_valid_o !== 2'b00) begin
            err++;
            $display("FAIL misp_after: count=%0d flush=%b ready=%b idx0=%0d commit=%b required 0 0 11 0 00",
                     bus.count_o, bus.flush_o, bus.disp_ready_o, bus.disp_rob_idx_o[0], bus.commit_valid_o);
        end
    endtask

    task automatic test_exception();
        bit ok;
        for (int c = 0; c < 4; c++) begin
            disp2(c, c, c, c, c, c);
            tick();
        end
        idle();
        for (int g = 0; g < 2; g++) begin
            bus.wb_valid_i = 4'b1111;
            for (int l = 0; l < 4; l++) bus.wb_rob_idx_i[l] = IDX_W'(4*g + l);
            tick();
        end
        idle();
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (bus.count_o == CNT_W'(0)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        disp2(1, 2, 3, 4, 5, 6);
        #1;
        vec++;
        if (!ok || bus.disp_rob_idx_o[0] !== IDX_W'(8) || bus.disp_rob_idx_o[1] !== IDX_W'(9)) begin
            err++;
            $display("FAIL exc_alloc: drained=%0d idx=%0d,%0d required 1 8,9",
                     ok, bus.disp_rob_idx_o[0], bus.disp_rob_idx_o[1]);
        end
        tick();
        idle();
        bus.wb_valid_i      = 4'b0011;
        bus.wb_rob_idx_i[0] = IDX_W'(8);
        bus.wb_rob_idx_i[1] = IDX_W'(9);
        bus.wb_exception_i  = 4'b0001;
        tick();
        idle();
        bus.disp_valid_i = 2'b11;
        #1;
        vec++;
        if (bus.commit_valid_o !== 2'b00 || bus.flush_o !== 1'b1 || bus.flush_exc_o !== 1'b1 ||
            bus.flush_rob_idx_o !== IDX_W'(8) || bus.disp_ready_o !== 2'b00) begin
            err++;
            $display("FAIL exc_flush: v=%b flush=%b exc=%b fidx=%0d ready=%b required 00 1 1 8 00",
                     bus.commit_valid_o, bus.flush_o, bus.flush_exc_o, bus.flush_rob_idx_o, bus.disp_ready_o);
        end
        tick();
        idle();
        #1;
        vec++;
        if (bus.count_o !== CNT_W'(0) || bus.flush_o !== 1'b0) begin
            err++;
            $display("FAIL exc_after: count=%0d flush=%b required 0 0", bus.count_o, bus.flush_o);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            disp2(c, c, c, c, c, c);
            if (c == 3) begin
                bus.disp_valid_i    = 2'b01;
                bus.wb_valid_i      = 4'b0011;
                bus.wb_rob_idx_i[0] = IDX_W'(0);
                bus.wb_rob_idx_i[1] = IDX_W'(1);
            end
            tick();
        end
        idle();
        #1;
        vec++;
        if (bus.count_o !== CNT_W'(7) || bus.commit_valid_o !== 2'b11) begin
            err++;
            $display("FAIL pre_reset: count=%0d commit=%b required 7 11", bus.count_o, bus.commit_valid_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vec++;
        if (bus.count_o !== CNT_W'(0) || bus.commit_valid_o !== 2'b00 || bus.flush_o !== 1'b0) begin
            err++;
            $display("FAIL async_reset: count=%0d commit=%b flush=%b required 0 00 0",
                     bus.count_o, bus.commit_valid_o, bus.flush_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        vec     = 0;
        err     = 0;
        reset_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        test_fill();
        test_inorder();
        test_wrap();
        test_mispredict();
        test_exception();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
